// File: rtl/nios2_debug_sysclk_cmdq_pkg.sv
// Shared definitions for the Nios II debug system-clock command queue:
// virtual-JTAG instruction codes, default geometry and the queue entry record.
package nios2_debug_sysclk_cmdq_pkg;

  localparam int DEF_SR_W    = 32'd38;
  localparam int DEF_IR_W    = 32'd2;
  localparam int DEF_DEPTH   = 32'd4;
  localparam int DEF_ACT_BIT = 32'd35;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACE     = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  // One queued debug command: the instruction in force at update-DR time
  // together with the shift-register snapshot taken at that moment.
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] sr;
  } cmd_entry_t;

endpackage

// File: rtl/nios2_debug_sysclk_cmdq_fifo.sv
// Show-ahead command FIFO with modulo-DEPTH pointers and a sticky overflow
// flag. The head entry is presented combinationally; an empty queue reads 0.
module dbg_cmd_fifo #(
  parameter int W     = 32'd40,
  parameter int DEPTH = 32'd4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               data_in,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  logic          empty_s;
  logic          full_s;
  logic          do_pop_s;
  logic          do_push_s;
  logic          drop_s;

  // Pointer advance that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A pop frees a slot in the same edge, so a push onto a full queue is only
  // dropped when nothing leaves at that edge.
  assign empty_s   = (count_r == CW'(0));
  assign full_s    = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);
  assign drop_s    = push & full_s & ~do_pop_s;

  // Entry storage; contents are qualified by count so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a drop at the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign valid    = ~empty_s;
  assign data_out = empty_s ? '0 : mem_r[rd_ptr_r];
  assign count    = count_r;
  assign ovf      = ovf_r;

endmodule

// File: rtl/nios2_debug_sysclk_cmdq.sv
// Brings virtual-JTAG update-IR / update-DR events from the TCK domain into
// the system clock domain and queues each update-DR as a debug command.
module nios2_debug_sysclk_cmdq
  import nios2_debug_sysclk_cmdq_pkg::*;
#(
  parameter int SR_W    = DEF_SR_W,
  parameter int IR_W    = DEF_IR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ACT_BIT = DEF_ACT_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [IR_W-1:0]            act_ir,
  output logic                       act_take,
  output logic [SR_W-1:0]            jdo,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int DW = IR_W + SR_W;

  // Bit 0 and 1 form the synchronizer, bit 2 is the edge-detect history.
  logic [2:0]      uir_sync_r;
  logic [2:0]      udr_sync_r;
  // Counts edges since reset until the edge-detect flop holds a real sample.
  logic [1:0]      fill_r;
  logic [IR_W-1:0] ir_q_r;

  logic            uir_rise_s;
  logic            udr_rise_s;
  logic [DW-1:0]   push_data_s;
  logic [DW-1:0]   head_s;

  // Two-flop synchronizers plus edge-detect stage for both update strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync_r <= 3'b000;
      udr_sync_r <= 3'b000;
    end else begin
      uir_sync_r <= {uir_sync_r[1:0], vs_uir};
      udr_sync_r <= {udr_sync_r[1:0], vs_udr};
    end
  end

  // Until the history flop has seen a genuine sample, a level that was already
  // high across reset must not look like a fresh update-DR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_r <= 2'd0;
    end else if (fill_r != 2'd3) begin
      fill_r <= fill_r + 2'd1;
    end
  end

  assign uir_rise_s = uir_sync_r[1] & ~uir_sync_r[2];
  assign udr_rise_s = udr_sync_r[1] & ~udr_sync_r[2] & (fill_r == 2'd3);

  // Instruction register; a push at the same edge still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q_r <= '0;
    end else if (uir_rise_s) begin
      ir_q_r <= ir_in;
    end
  end

  assign push_data_s = {ir_q_r, sr};

  dbg_cmd_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (udr_rise_s),
    .data_in  (push_data_s),
    .pop      (act_ready),
    .valid    (act_valid),
    .data_out (head_s),
    .count    (count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  assign act_ir   = head_s[SR_W +: IR_W];
  assign jdo      = head_s[SR_W-1:0];
  assign act_take = head_s[ACT_BIT];

endmodule

// File: tb/tb_nios2_debug_sysclk_cmdq.sv
// Bench for nios2_debug_sysclk_cmdq: a DEPTH=4 and a DEPTH=3 instance share
// the stimulus; each is compared every cycle with a queue-based reference.
module tb_nios2_debug_sysclk_cmdq;
  import nios2_debug_sysclk_cmdq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic        act_ready;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D  = (g == 0) ? 4 : 3;
    localparam int CW = $clog2(D + 1);

    logic          act_valid;
    logic [1:0]    act_ir;
    logic          act_take;
    logic [37:0]   jdo;
    logic [CW-1:0] count;
    logic          ovf;

    nios2_debug_sysclk_cmdq #(
      .SR_W(38), .IR_W(2), .DEPTH(D), .ACT_BIT(35)
    ) dut (
      .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
      .vs_uir(vs_uir), .vs_udr(vs_udr),
      .act_valid(act_valid), .act_ready(act_ready), .act_ir(act_ir),
      .act_take(act_take), .jdo(jdo), .count(count), .ovf(ovf),
      .ovf_clr(ovf_clr)
    );

    // Reference: levels sampled since reset; a strobe counts as risen when the
    // sample two edges back is high and the one before it is low.
    cmd_entry_t q[$];
    bit         uh[$];
    bit         dh[$];
    logic [1:0] mir;
    bit         movf;
    int         n;
    bit         push_m, latch_m, pop_m, drop_m;
    cmd_entry_t e_m;
    cmd_entry_t h_m;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        q.delete(); uh.delete(); dh.delete();
        mir  = 2'd0;
        movf = 1'b0;
      end else begin
        n       = dh.size();
        push_m  = (n >= 3) && dh[n-2] && !dh[n-3];
        latch_m = (n >= 2) && uh[n-2] && ((n < 3) || !uh[n-3]);
        e_m.ir  = mir;
        e_m.sr  = sr;
        pop_m   = act_ready && (q.size() > 0);
        drop_m  = push_m && (q.size() == D) && !pop_m;
        if (pop_m) void'(q.pop_front());
        if (push_m && !drop_m) q.push_back(e_m);
        if (drop_m) movf = 1'b1;
        else if (ovf_clr) movf = 1'b0;
        if (latch_m) mir = ir_in;
        uh.push_back(vs_uir);
        dh.push_back(vs_udr);
      end
    end

    always @(negedge clk) begin
      h_m = (q.size() > 0) ? q[0] : '0;
      chk($sformatf("d%0d.act_valid", D), 64'(act_valid), 64'(q.size() > 0));
      chk($sformatf("d%0d.act_ir", D),    64'(act_ir),    64'(h_m.ir));
      chk($sformatf("d%0d.act_take", D),  64'(act_take),  64'(h_m.sr[DEF_ACT_BIT]));
      chk($sformatf("d%0d.jdo", D),       64'(jdo),       64'(h_m.sr));
      chk($sformatf("d%0d.count", D),     64'(count),     64'(q.size()));
      chk($sformatf("d%0d.ovf", D),       64'(ovf),       64'(movf));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic udr_pulse(input logic [37:0] v);
    sr = v;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic uir_pulse(input logic [1:0] v);
    ir_in = v;
    vs_uir = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain();
    act_ready = 1'b1;
    repeat (5) tick();
    act_ready = 1'b0;
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ir_in = 2'd0; sr = 38'd0; vs_uir = 1'b0; vs_udr = 1'b0;
    act_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst.act_valid", 64'(u[0].act_valid), 64'd0);
    chk("rst.jdo", 64'(u[0].jdo), 64'd0);
    chk("rst.count", 64'(u[0].count), 64'd0);
    chk("rst.ovf", 64'(u[0].ovf), 64'd0);
    reset = 1'b0;
    repeat (5) tick();

    // Single command and its three-edge latency.
    uir_pulse(IR_BREAK);
    sr = 38'h08_0000_0001;
    vs_udr = 1'b1;
    tick();
    tick();
    chk("lat.valid_e2", 64'(u[0].act_valid), 64'd0);
    tick();
    chk("lat.valid_e3", 64'(u[0].act_valid), 64'd1);
    vs_udr = 1'b0;
    chk("single.act_ir", 64'(u[0].act_ir), 64'd2);
    chk("single.act_take", 64'(u[0].act_take), 64'd1);
    chk("single.jdo", 64'(u[0].jdo), 64'h08_0000_0001);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    chk("single.count", 64'(u[0].count), 64'd0);
    repeat (3) tick();

    // Overflow: five pushes into four slots.
    for (int v = 1; v <= 5; v++) udr_pulse(38'(v));
    chk("ovf.count", 64'(u[0].count), 64'd4);
    chk("ovf.flag", 64'(u[0].ovf), 64'd1);
    act_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("ovf.order%0d", v), 64'(u[0].jdo), 64'(v));
      tick();
    end
    act_ready = 1'b0;
    chk("ovf.drained", 64'(u[0].count), 64'd0);
    clear_ovf();
    chk("ovf.cleared", 64'(u[0].ovf), 64'd0);

    // Full queue with a push and a pop landing on the same edge.
    for (int v = 1; v <= 4; v++) udr_pulse(38'h10 + 38'(v));
    sr = 38'h15;
    vs_udr = 1'b1;
    tick();
    tick();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    vs_udr = 1'b0;
    chk("full.count", 64'(u[0].count), 64'd4);
    chk("full.ovf", 64'(u[0].ovf), 64'd0);
    act_ready = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      chk($sformatf("full.order%0d", v), 64'(u[0].jdo), 64'h10 + 64'(v));
      tick();
    end
    act_ready = 1'b0;
    clear_ovf();
    repeat (2) tick();

    // Coincident update-IR and update-DR: push carries the old instruction.
    uir_pulse(IR_TRACE);
    ir_in = IR_TRACECTRL;
    sr = 38'h21;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (3) tick();
    chk("coinc.first_ir", 64'(u[0].act_ir), 64'd1);
    udr_pulse(38'h22);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    chk("coinc.next_ir", 64'(u[0].act_ir), 64'd3);
    drain();

    // Reset with commands queued and update-DR held high.
    for (int v = 0; v < 3; v++) udr_pulse(38'h30 + 38'(v));
    vs_udr = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid.count", 64'(u[0].count), 64'd0);
    chk("rstmid.valid", 64'(u[0].act_valid), 64'd0);
    reset = 1'b0;
    repeat (6) tick();
    chk("rstmid.held_no_push", 64'(u[0].count), 64'd0);
    vs_udr = 1'b0;
    repeat (3) tick();
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    chk("rstmid.repush", 64'(u[0].count), 64'd1);
    drain();

    // Pointer wrap on the three-entry instance.
    for (int v = 0; v < 10; v++) begin
      udr_pulse(38'(v));
      chk($sformatf("wrap.val%0d", v), 64'(u[1].jdo), 64'(v));
      act_ready = 1'b1;
      tick();
      act_ready = 1'b0;
    end
    chk("wrap.ovf", 64'(u[1].ovf), 64'd0);
    chk("wrap.empty", 64'(u[1].count), 64'd0);

    // Random traffic, including occasional resets and clears.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) vs_udr = ~vs_udr;
      if ($urandom_range(0, 4) == 0) vs_uir = ~vs_uir;
      ir_in     = 2'($urandom);
      sr        = {6'($urandom), 32'($urandom)};
      act_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
